// File: rtl/alu_bist.sv
// ---------------------------------------------------------------------------
// alu_bist : built-in self-test controller for the 4-bit combinational ALU.
//
// A 10-bit maximal-length LFSR (x^10 + x^7 + 1) supplies A/B/sel for
// N_PATTERNS consecutive cycles. The ALU response {cout, y} for each pattern
// is folded into a 16-bit MISR on the same edge that advances the LFSR, so
// pattern and response line up with zero pipeline stages. When the run ends
// the MISR is compared with GOLDEN and the verdict is held in DONE.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset
//   start       : run request, sampled in IDLE and DONE only
//   alu_a/b/sel : stimulus to the ALU (zero outside RUN)
//   alu_y/cout  : ALU response, combinational from alu_a/alu_b/alu_sel
//   busy        : high while in RUN
//   done        : high while in DONE
//   pass        : valid while done=1, 1 iff final signature == GOLDEN
//   signature   : current MISR contents, valid in every state
//   dbg_state_o : current FSM state (ST_IDLE/ST_RUN/ST_DONE encoding)
//
// Handshake: start is a level request with no acknowledge. It is acted on at
// any rising edge where the FSM is in IDLE or DONE and ignored during RUN;
// holding it high chains runs with exactly one DONE cycle between them.
// ---------------------------------------------------------------------------
module alu_bist #(
  parameter int unsigned N_PATTERNS = 64,
  parameter logic [15:0] GOLDEN     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [1:0]  alu_sel,
  input  logic [3:0]  alu_y,
  input  logic        alu_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [9:0] LFSR_SEED = 10'h001;
  localparam logic [9:0] CNT_LAST  = 10'(N_PATTERNS - 1);

  logic [1:0]  state_q, state_d;
  logic [9:0]  lfsr_q,  lfsr_d;
  logic [9:0]  cnt_q,   cnt_d;
  logic [15:0] sig_q,   sig_d;
  logic        pass_q,  pass_d;

  logic        in_run;
  logic        misr_fb;
  logic [15:0] misr_next;
  logic        lfsr_fb;

  assign in_run = (state_q == ST_RUN);

  // MISR: shift with feedback taps 15/13/12/10, then XOR the 5-bit response
  // into the low bits. This absorbs the pattern currently on the ALU inputs.
  assign misr_fb   = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];
  assign misr_next = {sig_q[14:0], misr_fb} ^ {11'b0, alu_cout, alu_y};

  assign lfsr_fb = lfsr_q[9] ^ lfsr_q[6];

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Every run starts from the same seed and a cleared signature so the
        // result never depends on what a previous run left behind.
        if (start) begin
          state_d = ST_RUN;
          lfsr_d  = LFSR_SEED;
          cnt_d   = '0;
          sig_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        sig_d  = misr_next;
        lfsr_d = {lfsr_q[8:0], lfsr_fb};
        cnt_d  = cnt_q + 10'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          pass_d  = (misr_next == GOLDEN);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  // Stimulus comes straight from the registered LFSR, gated to zero outside RUN.
  assign alu_a       = in_run ? lfsr_q[9:6] : 4'd0;
  assign alu_b       = in_run ? lfsr_q[5:2] : 4'd0;
  assign alu_sel     = in_run ? lfsr_q[1:0] : 2'd0;
  assign busy        = in_run;
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign signature   = sig_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_bist.sv
module tb_alu_bist;

  localparam int MODE_ALU   = 0;  // behavioural ALU
  localparam int MODE_CONST = 1;  // y=4'hF, cout=1 regardless of inputs
  localparam int MODE_FAULT = 2;  // behavioural ALU with y[0] stuck at 0

  // ---------------- reference model ----------------
  function automatic logic [4:0] alu_resp(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] sel, input int m);
    logic [4:0] r;
    case (sel)
      2'd0:    r = {1'b0, a} + {1'b0, b};
      2'd1:    r = {1'b0, a} - {1'b0, b};
      2'd2:    r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    if (m == MODE_CONST) r = 5'h1F;
    if (m == MODE_FAULT) r[0] = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [4:0] r);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ {11'd0, r};
  endfunction

  function automatic logic [15:0] golden_sig(input int n, input int m);
    logic [9:0]  l;
    logic [15:0] s;
    l = 10'h001;
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      s = misr(s, alu_resp(l[9:6], l[5:2], l[1:0], m));
      l = {l[8:0], l[9] ^ l[6]};
    end
    return s;
  endfunction

  localparam logic [15:0] G64 = golden_sig(64, MODE_ALU);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start4, start64, start1k;
  int   mode;
  int   n_vec = 0;
  int   n_err = 0;

  logic [9:0]  pat_tab [0:1022];
  logic [15:0] const_steps [0:4] = '{16'h0000, 16'h001F, 16'h0021, 16'h005D, 16'h00A5};

  // ---------------- DUT instances ----------------
  logic [3:0]  a4a, b4a, y4a, a4b, b4b, y4b, a64, b64, y64, a1k, b1k, y1k;
  logic [1:0]  s4a, s4b, s64, s1k, d4a, d4b, d64, d1k;
  logic        c4a, c4b, c64, c1k;
  logic        busy4a, done4a, pass4a, busy4b, done4b, pass4b;
  logic        busy64, done64, pass64, busy1k, done1k, pass1k;
  logic [15:0] sig4a, sig4b, sig64, sig1k;

  assign {c4a, y4a} = alu_resp(a4a, b4a, s4a, mode);
  assign {c4b, y4b} = alu_resp(a4b, b4b, s4b, mode);
  assign {c64, y64} = alu_resp(a64, b64, s64, mode);
  assign {c1k, y1k} = alu_resp(a1k, b1k, s1k, mode);

  alu_bist #(.N_PATTERNS(4), .GOLDEN(16'h00A5)) u4a (
    .clk(clk), .rst_n(rst_n), .start(start4), .alu_a(a4a), .alu_b(b4a), .alu_sel(s4a),
    .alu_y(y4a), .alu_cout(c4a), .busy(busy4a), .done(done4a), .pass(pass4a),
    .signature(sig4a), .dbg_state_o(d4a));

  alu_bist #(.N_PATTERNS(4), .GOLDEN(16'h00A4)) u4b (
    .clk(clk), .rst_n(rst_n), .start(start4), .alu_a(a4b), .alu_b(b4b), .alu_sel(s4b),
    .alu_y(y4b), .alu_cout(c4b), .busy(busy4b), .done(done4b), .pass(pass4b),
    .signature(sig4b), .dbg_state_o(d4b));

  alu_bist #(.N_PATTERNS(64), .GOLDEN(G64)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .alu_a(a64), .alu_b(b64), .alu_sel(s64),
    .alu_y(y64), .alu_cout(c64), .busy(busy64), .done(done64), .pass(pass64),
    .signature(sig64), .dbg_state_o(d64));

  alu_bist #(.N_PATTERNS(1023), .GOLDEN(16'h0000)) u1k (
    .clk(clk), .rst_n(rst_n), .start(start1k), .alu_a(a1k), .alu_b(b1k), .alu_sel(s1k),
    .alu_y(y1k), .alu_cout(c1k), .busy(busy1k), .done(done1k), .pass(pass1k),
    .signature(sig1k), .dbg_state_o(d1k));

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start4 = 1'b1; start64 = 1'b1; start1k = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_vec++;
      if ({busy4a, done4a, pass4a, a4a, b4a, s4a, sig4a} !== 29'd0) begin
        n_err++;
        $display("FAIL reset_u4a: got %h want 0", {busy4a, done4a, pass4a, a4a, b4a, s4a, sig4a});
      end
      n_vec++;
      if ({busy64, done64, pass64, busy1k, done1k, pass1k} !== 6'd0) begin
        n_err++;
        $display("FAIL reset_others: got %b want 0", {busy64, done64, pass64, busy1k, done1k, pass1k});
      end
    end
    start4 = 1'b0; start64 = 1'b0; start1k = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({busy4a, done4a, sig4a} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_idle_hold: got %h want 0", {busy4a, done4a, sig4a});
    end
  endtask

  task automatic test_stimulus_order();
    logic [15:0] es;
    logic [9:0]  p;
    mode = MODE_ALU; es = 16'h0000;
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      p = pat_tab[k];
      n_vec++;
      if ({busy4a, done4a, a4a, b4a, s4a, sig4a} !== {2'b10, p, es}) begin
        n_err++;
        $display("FAIL order k=%0d: got %h want %h", k, {busy4a, done4a, a4a, b4a, s4a, sig4a}, {2'b10, p, es});
      end
      es = misr(es, alu_resp(p[9:6], p[5:2], p[1:0], mode));
      @(posedge clk); #1;
    end
    n_vec++;
    if ({busy4a, done4a, pass4a, a4a, b4a, s4a, sig4a} !== {3'b01, (es == 16'h00A5), 10'd0, es}) begin
      n_err++;
      $display("FAIL order_done: got %h want %h", {busy4a, done4a, pass4a, a4a, b4a, s4a, sig4a},
               {2'b01, (es == 16'h00A5), 10'd0, es});
    end
  endtask

  task automatic test_misr();
    mode = MODE_CONST;
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({busy4a, sig4a, busy4b, sig4b} !== {1'b1, const_steps[k], 1'b1, const_steps[k]}) begin
        n_err++;
        $display("FAIL misr k=%0d: got %h/%h want %h", k, sig4a, sig4b, const_steps[k]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if ({done4a, pass4a, sig4a, done4b, pass4b, sig4b} !== {2'b11, 16'h00A5, 2'b10, 16'h00A5}) begin
      n_err++;
      $display("FAIL misr_pass: got a=%b%b/%h b=%b%b/%h want a=11/00a5 b=10/00a5",
               done4a, pass4a, sig4a, done4b, pass4b, sig4b);
    end
  endtask

  task automatic test_start_during_run();
    logic [9:0] p;
    mode = MODE_ALU;
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      p = pat_tab[k];
      n_vec++;
      if ({busy4a, done4a, a4a, b4a, s4a} !== {2'b10, p}) begin
        n_err++;
        $display("FAIL start_in_run k=%0d: got %h want %h", k, {busy4a, done4a, a4a, b4a, s4a}, {2'b10, p});
      end
      start4 = (k < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == 1) start4 = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if ({busy4a, done4a} !== 2'b01) begin
      n_err++;
      $display("FAIL start_in_run_len: got busy/done %b want 01", {busy4a, done4a});
    end
  endtask

  task automatic test_reset_mid_run();
    mode = MODE_CONST;
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if ({busy4a, sig4a} !== {1'b1, const_steps[2]}) begin
      n_err++;
      $display("FAIL mid_run_pre: got %h want %h", {busy4a, sig4a}, {1'b1, const_steps[2]});
    end
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    n_vec++;
    if ({busy4a, done4a, pass4a, a4a, b4a, s4a, sig4a} !== 29'd0) begin
      n_err++;
      $display("FAIL mid_run_reset: got %h want 0", {busy4a, done4a, pass4a, a4a, b4a, s4a, sig4a});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({busy4a, done4a, sig4a} !== 18'd0) begin
      n_err++;
      $display("FAIL mid_run_idle: got %h want 0", {busy4a, done4a, sig4a});
    end
  endtask

  task automatic test_back_to_back();
    mode = MODE_CONST;
    start4 = 1'b1; @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if ({busy4a, done4a, sig4a} !== {2'b10, const_steps[k]}) begin
          n_err++;
          $display("FAIL b2b r=%0d k=%0d: got %h want %h", r, k, {busy4a, done4a, sig4a}, {2'b10, const_steps[k]});
        end
        @(posedge clk); #1;
      end
      n_vec++;
      if ({busy4a, done4a, pass4a, sig4a} !== {3'b011, 16'h00A5}) begin
        n_err++;
        $display("FAIL b2b_done r=%0d: got %h want %h", r, {busy4a, done4a, pass4a, sig4a}, {3'b011, 16'h00A5});
      end
      if (r == 1) start4 = 1'b0;
      @(posedge clk); #1;
    end
    n_vec++;
    if ({busy4a, done4a, sig4a} !== {2'b01, 16'h00A5}) begin
      n_err++;
      $display("FAIL b2b_hold: got %h want %h", {busy4a, done4a, sig4a}, {2'b01, 16'h00A5});
    end
  endtask

  task automatic test_fault_detect();
    logic [15:0] es;
    logic [9:0]  p;
    for (int f = 0; f < 2; f++) begin
      mode = (f == 0) ? MODE_ALU : MODE_FAULT;
      es = 16'h0000;
      start64 = 1'b1; @(posedge clk); #1; start64 = 1'b0;
      for (int k = 0; k < 64; k++) begin
        p = pat_tab[k];
        n_vec++;
        if ({busy64, done64, a64, b64, s64, sig64} !== {2'b10, p, es}) begin
          n_err++;
          $display("FAIL fault f=%0d k=%0d: got %h want %h", f, k, {busy64, done64, a64, b64, s64, sig64}, {2'b10, p, es});
        end
        es = misr(es, alu_resp(p[9:6], p[5:2], p[1:0], mode));
        @(posedge clk); #1;
      end
      n_vec++;
      if ({busy64, done64, pass64, sig64} !== {2'b01, (f == 0), es}) begin
        n_err++;
        $display("FAIL fault_verdict f=%0d: got %h want %h", f, {busy64, done64, pass64, sig64}, {2'b01, (f == 0), es});
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] es;
    logic [9:0]  p;
    int          gap;
    for (int r = 0; r < 4; r++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        n_vec++;
        if ({busy64, done64} !== 2'b01) begin
          n_err++;
          $display("FAIL rand_gap r=%0d: got %b want 01", r, {busy64, done64});
        end
      end
      mode = ($urandom_range(0, 1) == 0) ? MODE_ALU : MODE_FAULT;
      es = 16'h0000;
      start64 = 1'b1; @(posedge clk); #1;
      for (int k = 0; k < 64; k++) begin
        p = pat_tab[k];
        start64 = (k < 63) ? 1'($urandom_range(0, 1)) : 1'b0;
        n_vec++;
        if ({busy64, done64, a64, b64, s64, sig64} !== {2'b10, p, es}) begin
          n_err++;
          $display("FAIL rand r=%0d k=%0d: got %h want %h", r, k, {busy64, done64, a64, b64, s64, sig64}, {2'b10, p, es});
        end
        es = misr(es, alu_resp(p[9:6], p[5:2], p[1:0], mode));
        @(posedge clk); #1;
      end
      n_vec++;
      if ({busy64, done64, pass64, sig64} !== {2'b01, (es == G64), es}) begin
        n_err++;
        $display("FAIL rand_done r=%0d: got %h want %h", r, {busy64, done64, pass64, sig64}, {2'b01, (es == G64), es});
      end
    end
  endtask

  task automatic test_full_length();
    logic [15:0]  es;
    logic [9:0]   p;
    logic [9:0]   obs;
    bit [1023:0]  seen;
    mode = MODE_ALU; es = 16'h0000; seen = '0;
    start1k = 1'b1; @(posedge clk); #1; start1k = 1'b0;
    for (int k = 0; k < 1023; k++) begin
      p = pat_tab[k];
      obs = {a1k, b1k, s1k};
      n_vec++;
      if ({busy1k, done1k, obs, sig1k} !== {2'b10, p, es}) begin
        n_err++;
        $display("FAIL full k=%0d: got %h want %h", k, {busy1k, done1k, obs, sig1k}, {2'b10, p, es});
      end
      n_vec++;
      if (seen[obs] !== 1'b0) begin
        n_err++;
        $display("FAIL full_distinct k=%0d: pattern %h repeated, want unseen", k, obs);
      end
      seen[obs] = 1'b1;
      es = misr(es, alu_resp(p[9:6], p[5:2], p[1:0], mode));
      @(posedge clk); #1;
    end
    n_vec++;
    if ({busy1k, done1k, pass1k, sig1k} !== {2'b01, (es == 16'h0000), es}) begin
      n_err++;
      $display("FAIL full_done: got %h want %h", {busy1k, done1k, pass1k, sig1k}, {2'b01, (es == 16'h0000), es});
    end
    n_vec++;
    if (u1k.lfsr_q !== 10'h001) begin
      n_err++;
      $display("FAIL full_lfsr_wrap: got %h want 001", u1k.lfsr_q);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] l;
    rst_n = 1'b0; start4 = 1'b0; start64 = 1'b0; start1k = 1'b0; mode = MODE_ALU;
    l = 10'h001;
    for (int i = 0; i < 1023; i++) begin
      pat_tab[i] = l;
      l = {l[8:0], l[9] ^ l[6]};
    end
    test_reset();
    test_stimulus_order();
    test_misr();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_fault_detect();
    test_random();
    test_full_length();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
